// File: rtl/demux1to2_reg.sv
// Registered 1-to-2 demultiplexer: steers an 8-bit stream into one of two one-entry holding registers.
// Optional per-port transfer counters (Count1/Count2) are built when DEMUX_COUNT_EN is defined.
module demux1to2_reg (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] In,
    input  logic       InValid,
    input  logic       Selector,
    output logic       InReady,
    output logic [7:0] Out1,
    output logic [7:0] Out2,
    output logic       Out1Valid,
    output logic       Out2Valid,
    input  logic       Out1Ready,
    input  logic       Out2Ready,
    output logic [1:0] PortState
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0] Count1,
    output logic [7:0] Count2
`endif
);

    // Handshake: a beat moves when valid && ready are both high at a rising edge. Valids never
    // depend on ready; InReady depends only on Selector and the selected port's state/ready,
    // never on InValid. A port that is FULL and being drained may be refilled on the same edge.

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_t;

    port_state_t state1;
    port_state_t state2;

    logic load1;
    logic load2;
    logic drain1;
    logic drain2;

    assign Out1Valid = (state1 == FULL);
    assign Out2Valid = (state2 == FULL);
    assign PortState = {Out2Valid, Out1Valid};

    assign InReady = Selector ? (!Out2Valid || Out2Ready)
                              : (!Out1Valid || Out1Ready);

    assign load1  = InValid && InReady && !Selector;
    assign load2  = InValid && InReady &&  Selector;
    assign drain1 = Out1Valid && Out1Ready;
    assign drain2 = Out2Valid && Out2Ready;

    // A load takes priority over a drain, so drain+load keeps the port FULL with the new data.
    // Data registers are not cleared on drain; they only change on a load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state1 <= EMPTY;
            state2 <= EMPTY;
            Out1   <= 8'h00;
            Out2   <= 8'h00;
`ifdef DEMUX_COUNT_EN
            Count1 <= 8'h00;
            Count2 <= 8'h00;
`endif
        end else begin
            if (load1) begin
                state1 <= FULL;
                Out1   <= In;
`ifdef DEMUX_COUNT_EN
                Count1 <= Count1 + 8'd1;
`endif
            end else if (drain1) begin
                state1 <= EMPTY;
            end

            if (load2) begin
                state2 <= FULL;
                Out2   <= In;
`ifdef DEMUX_COUNT_EN
                Count2 <= Count2 + 8'd1;
`endif
            end else if (drain2) begin
                state2 <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_demux1to2_reg.sv
// Self-checking bench for demux1to2_reg: directed scenarios plus randomized traffic against a
// per-port reference model with delivery scoreboards. Counter checks build with DEMUX_COUNT_EN.
module tb_demux1to2_reg;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] In;
    logic       InValid;
    logic       Selector;
    logic       InReady;
    logic [7:0] Out1;
    logic [7:0] Out2;
    logic       Out1Valid;
    logic       Out2Valid;
    logic       Out1Ready;
    logic       Out2Ready;
    logic [1:0] PortState;
`ifdef DEMUX_COUNT_EN
    logic [7:0] Count1;
    logic [7:0] Count2;
`endif

    demux1to2_reg dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .In        (In),
        .InValid   (InValid),
        .Selector  (Selector),
        .InReady   (InReady),
        .Out1      (Out1),
        .Out2      (Out2),
        .Out1Valid (Out1Valid),
        .Out2Valid (Out2Valid),
        .Out1Ready (Out1Ready),
        .Out2Ready (Out2Ready),
        .PortState (PortState)
`ifdef DEMUX_COUNT_EN
        ,
        .Count1    (Count1),
        .Count2    (Count2)
`endif
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: per-port occupancy, held data, transfer count
    bit         mdl_full[2];
    logic [7:0] mdl_data[2];
    int         mdl_cnt[2];
    // scoreboard: values each consumer is expected to receive, in order
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mdl_full[k] = 1'b0;
            mdl_data[k] = 8'h00;
            mdl_cnt[k]  = 0;
        end
        exp_q1.delete();
        exp_q2.delete();
    endtask

    function automatic bit mdl_ready(input bit sel, input bit r1, input bit r2);
        return !mdl_full[sel] || (sel ? r2 : r1);
    endfunction

    task automatic check_outputs();
        check_eq("Out1", Out1, mdl_data[0]);
        check_eq("Out2", Out2, mdl_data[1]);
        check_eq("Out1Valid", Out1Valid, mdl_full[0]);
        check_eq("Out2Valid", Out2Valid, mdl_full[1]);
        check_eq("PortState", PortState, {mdl_full[1], mdl_full[0]});
`ifdef DEMUX_COUNT_EN
        check_eq("Count1", Count1, mdl_cnt[0] % 256);
        check_eq("Count2", Count2, mdl_cnt[1] % 256);
`endif
    endtask

    // driver: one clock cycle of stimulus, checked before the edge, model advanced at the edge
    task automatic do_cycle(input logic [7:0] d, input bit v, input bit s, input bit r1, input bit r2);
        bit acc;
        bit drn[2];
        logic [7:0] exp_v;
        @(negedge clock);
        In = d; InValid = v; Selector = s; Out1Ready = r1; Out2Ready = r2;
        #1;
        check_outputs();
        check_eq("InReady", InReady, mdl_ready(s, r1, r2));
        acc    = v && mdl_ready(s, r1, r2);
        drn[0] = mdl_full[0] && r1;
        drn[1] = mdl_full[1] && r2;
        if (drn[0]) begin
            if (exp_q1.size() == 0) check_eq("drain1_empty_q", 1, 0);
            else begin
                exp_v = exp_q1.pop_front();
                check_eq("drain1_data", Out1, exp_v);
            end
        end
        if (drn[1]) begin
            if (exp_q2.size() == 0) check_eq("drain2_empty_q", 1, 0);
            else begin
                exp_v = exp_q2.pop_front();
                check_eq("drain2_data", Out2, exp_v);
            end
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++)
            if (drn[k]) mdl_full[k] = 1'b0;
        if (acc) begin
            mdl_full[s] = 1'b1;
            mdl_data[s] = d;
            mdl_cnt[s]  = mdl_cnt[s] + 1;
            if (s) exp_q2.push_back(d);
            else   exp_q1.push_back(d);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        InValid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // producer rule: a stalled request must be held stable until accepted
    logic       stall_q = 1'b0;
    logic [7:0] in_q;
    logic       sel_q;
    always @(posedge clock) begin
        if (reset_n && stall_q && InValid)
            assert (In == in_q && Selector == sel_q)
            else $error("producer changed a stalled request");
        stall_q <= reset_n && InValid && !InReady;
        in_q    <= In;
        sel_q   <= Selector;
    end

    initial begin
        logic [7:0] d;
        bit v, s, r1, r2, held;

        reset_n = 1'b0; In = 8'h00; InValid = 1'b0; Selector = 1'b0;
        Out1Ready = 1'b0; Out2Ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;

        // basic steer
        do_cycle(8'hFF, 1, 0, 0, 0);
        do_cycle(8'h55, 1, 1, 0, 0);
        #1;
        check_eq("steer_out1", Out1, 8'hFF);
        check_eq("steer_out2", Out2, 8'h55);
        check_eq("steer_valid", {Out2Valid, Out1Valid}, 2'b11);

        // backpressure on port 1, then drain+refill on the same edge
        do_cycle(8'hAA, 1, 0, 1, 1);
        do_cycle(8'h11, 1, 0, 0, 1);
        #1;
        check_eq("bp_hold_out1", Out1, 8'hAA);
        do_cycle(8'h11, 1, 0, 1, 0);
        #1;
        check_eq("refill_out1", Out1, 8'h11);
        check_eq("refill_valid1", Out1Valid, 1'b1);

        // independence: port 1 stalled, port 2 still accepts
        do_cycle(8'h22, 1, 1, 0, 1);
        #1;
        check_eq("indep_out2", Out2, 8'h22);
        check_eq("indep_out1", Out1, 8'h11);

        // streaming with both consumers ready
        for (int i = 0; i < 8; i++)
            do_cycle(i[7:0], 1, i[0], 1, 1);
        do_cycle(8'h00, 0, 0, 1, 1);

        // asynchronous reset mid-cycle with port 1 FULL
        do_cycle(8'hA5, 1, 0, 0, 0);
        @(negedge clock);
        InValid = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_valid1", Out1Valid, 1'b0);
        check_eq("async_rst_out1", Out1, 8'h00);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        Selector = 1'b0;
        #1;
        check_eq("rst_inready_sel0", InReady, 1'b1);
        Selector = 1'b1;
        #1;
        check_eq("rst_inready_sel1", InReady, 1'b1);

        // randomized traffic
        held = 1'b0; d = 8'h00; v = 1'b0; s = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                d = 8'($urandom_range(0, 255));
                v = ($urandom_range(0, 3) != 0);
                s = 1'($urandom_range(0, 1));
            end
            r1 = ($urandom_range(0, 2) != 0);
            r2 = ($urandom_range(0, 2) != 0);
            held = v && !mdl_ready(s, r1, r2);
            do_cycle(d, v, s, r1, r2);
        end

`ifdef DEMUX_COUNT_EN
        apply_reset();
        for (int i = 0; i < 257; i++)
            do_cycle(8'($urandom_range(0, 255)), 1, 1, 0, 1);
        #1;
        check_eq("count2_wrap", Count2, 8'd1);
        check_eq("count1_idle", Count1, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
